// File: rtl/wishbone_sram_slave_if.sv
// Classic Wishbone B4 bus bundle shared by the SRAM slave and its masters.
//   adr, dat_w, sel, we, stb, cyc, cti, bte : master -> slave
//   dat_r, ack, err                         : slave  -> master
interface wishbone_interface;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;

    modport slave (
        input  adr, dat_w, sel, we, stb, cyc, cti, bte,
        output dat_r, ack, err
    );

    modport master (
        output adr, dat_w, sel, we, stb, cyc, cti, bte,
        input  dat_r, ack, err
    );
endinterface

// File: rtl/wishbone_sram_slave.sv
// Single-port SRAM behind a classic (single-beat) Wishbone B4 slave port.
// A request is latched in IDLE, optionally delayed by WAIT_STATES cycles,
// then answered with a one-cycle ack (in range) or err (out of range).
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (memory contents are kept)
//   wishbone : slave side of the Wishbone bus (cti/bte are ignored)
//   busy     : high while a latched transfer awaits its ack/err
module wishbone_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    wishbone_interface.slave wishbone,
    output logic             busy
);

    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(64'(DEPTH_WORDS) * 64'd4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          hit_q, hit_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          go_resp;
    logic          mem_en;
    logic [31:0]   rdata_q;
    logic [31:0]   offset;
    logic          req;
    logic          unused_bits;

    logic [31:0] mem [DEPTH_WORDS];

    assign offset      = wishbone.adr - BASE_ADDR;
    assign req         = wishbone.cyc & wishbone.stb;
    assign unused_bits = ^{wishbone.cti, wishbone.bte};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        hit_d   = hit_q;
        go_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d = offset[AW+1:2];
                    dat_d = wishbone.dat_w;
                    sel_d = wishbone.sel;
                    we_d  = wishbone.we;
                    hit_d = ({1'b0, offset} < SPAN);
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                // Master dropping cyc or stb abandons the transfer silently.
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The *_d request fields equal the live bus when RESP is entered straight
    // from IDLE and the latched copy otherwise, so the RAM always uses them.
    assign ack_d  = go_resp & hit_d;
    assign err_d  = go_resp & ~hit_d;
    assign mem_en = go_resp & hit_d & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
        idx_q <= idx_d;
        dat_q <= dat_d;
        sel_q <= sel_d;
        we_q  <= we_d;
        hit_q <= hit_d;
    end

    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (we_d) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (sel_d[i]) begin
                        mem[idx_d][8*i +: 8] <= dat_d[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[idx_d];
            end
        end
    end

    assign wishbone.ack   = ack_q;
    assign wishbone.err   = err_q;
    assign wishbone.dat_r = (ack_q && !we_q) ? rdata_q : '0;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_wishbone_sram_slave.sv
module tb_wishbone_sram_slave;

    localparam int unsigned NDUT = 4;
    localparam int unsigned WS_T    [NDUT] = '{0, 3, 2, 4};
    localparam int unsigned DEPTH_T [NDUT] = '{1024, 256, 1024, 1024};
    localparam logic [31:0] BASE_T  [NDUT] = '{32'h0000_0000, 32'h1000_0000,
                                               32'h2000_0000, 32'h0004_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    int unsigned tgt;

    logic [NDUT-1:0] ack_v, err_v, busy_v;
    logic [31:0]     rd_v [NDUT];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl  [NDUT][1024];
    bit          mval [NDUT][1024];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        wishbone_interface wb ();
        assign wb.adr   = m_adr;
        assign wb.dat_w = m_dat;
        assign wb.sel   = m_sel;
        assign wb.we    = m_we;
        assign wb.cyc   = m_cyc && (tgt == k);
        assign wb.stb   = m_stb && (tgt == k);
        assign wb.cti   = '0;
        assign wb.bte   = '0;
        assign ack_v[k] = wb.ack;
        assign err_v[k] = wb.err;
        assign rd_v[k]  = wb.dat_r;

        wishbone_sram_slave #(
            .DEPTH_WORDS (DEPTH_T[k]),
            .BASE_ADDR   (BASE_T[k]),
            .WAIT_STATES (WS_T[k])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wishbone (wb.slave),
            .busy     (busy_v[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags(input int unsigned inst);
        return {29'b0, ack_v[inst], err_v[inst], busy_v[inst]};
    endfunction

    function automatic bit in_rng(input int unsigned inst, input logic [31:0] adr);
        logic [31:0] off;
        off = adr - BASE_T[inst];
        return off < 4 * DEPTH_T[inst];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // One complete classic transfer: response expected exactly WS+1 edges after drive.
    task automatic xfer(input int unsigned inst, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input bit keep_cyc,
                        output logic [31:0] rdata);
        bit          hit;
        int unsigned w;
        hit = in_rng(inst, adr);
        w   = (adr - BASE_T[inst]) >> 2;
        tgt = inst; m_adr = adr; m_dat = dat; m_sel = sel; m_we = we;
        m_cyc = 1'b1; m_stb = 1'b1;
        for (int unsigned j = 0; j < WS_T[inst]; j++) begin
            @(posedge clk); #1;
            check("wait_flags", flags(inst), 32'd1);
        end
        @(posedge clk); #1;
        check("resp_flags", flags(inst), {29'b0, hit, !hit, 1'b1});
        rdata = rd_v[inst];
        if (!hit) check("err_dat_r", rd_v[inst], 32'h0);
        else if (!we) check("rd_data", rd_v[inst], mdl[inst][w]);
        if (we && hit) begin
            mdl[inst][w]  = merge(mdl[inst][w], dat, sel);
            mval[inst][w] = 1'b1;
        end
        @(posedge clk); #1;
        m_stb = 1'b0;
        if (!keep_cyc) m_cyc = 1'b0;
        check("idle_flags", flags(inst), 32'd0);
        check("idle_dat_r", rd_v[inst], 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned inst, wi;
        bit          wr;
        logic [31:0] a;

        rst = 1'b1; tgt = 0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int unsigned k = 0; k < NDUT; k++) begin
            check("reset_flags", flags(k), 32'd0);
            check("reset_dat_r", rd_v[k], 32'h0);
        end
        rst = 1'b0;

        // Baseline at 0x40, then a request presented under reset must be ignored.
        xfer(0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, 1'b0, rd);
        rst = 1'b1; tgt = 0; m_adr = 32'h40; m_dat = 32'h5555_AAAA; m_sel = 4'hF;
        m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_flags", flags(0), 32'd0);
        m_cyc = 1'b0; m_stb = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("rst_req_idle", flags(0), 32'd0);
        xfer(0, 1'b0, 32'h40, '0, 4'hF, 1'b0, rd);

        // Zero-wait write/read, then byte-lane merge.
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
        xfer(0, 1'b0, 32'h10, '0, 4'hF, 1'b0, rd);
        check("deadbeef", rd, 32'hDEAD_BEEF);
        xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b0, rd);
        xfer(0, 1'b0, 32'h10, '0, 4'h0, 1'b0, rd);
        check("byte_sel", rd, 32'hDE22_BE44);

        // Range boundaries: last word is in range, one past the end errors.
        xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, rd);
        xfer(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
        xfer(0, 1'b0, 32'h0, '0, 4'hF, 1'b0, rd);
        check("oob_word0", rd, 32'hCAFE_F00D);
        xfer(0, 1'b1, 32'hFFC, 32'h0102_0304, 4'hF, 1'b0, rd);
        xfer(0, 1'b0, 32'hFFC, '0, 4'hF, 1'b0, rd);

        // Three wait states with a non-zero base; below-base wraps out of range.
        xfer(1, 1'b1, 32'h1000_0008, 32'h7654_3210, 4'hF, 1'b0, rd);
        xfer(1, 1'b0, 32'h1000_0008, '0, 4'hF, 1'b0, rd);
        xfer(1, 1'b0, 32'h0FFF_FFFC, '0, 4'hF, 1'b0, rd);
        xfer(1, 1'b1, 32'h1000_0400, 32'h1111_1111, 4'hF, 1'b0, rd);

        // Abort during WAIT.
        xfer(2, 1'b1, 32'h2000_0020, 32'h1234_5678, 4'hF, 1'b0, rd);
        tgt = 2; m_adr = 32'h2000_0020; m_dat = 32'hFFFF_FFFF; m_sel = 4'hF;
        m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", flags(2), 32'd1);
        m_stb = 1'b0; m_cyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", flags(2), 32'd0);
        end
        xfer(2, 1'b0, 32'h2000_0020, '0, 4'hF, 1'b0, rd);
        check("abort_keep", rd, 32'h1234_5678);

        // Reset while in WAIT.
        xfer(3, 1'b1, 32'h0004_0030, 32'hA5A5_A5A5, 4'hF, 1'b0, rd);
        tgt = 3; m_adr = 32'h0004_0030; m_dat = 32'h5A5A_5A5A; m_sel = 4'hF;
        m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        check("rstmid_busy", flags(3), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        check("rstmid_clear", flags(3), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rstmid_quiet", flags(3), 32'd0);
        end
        xfer(3, 1'b0, 32'h0004_0030, '0, 4'hF, 1'b0, rd);
        check("rstmid_keep", rd, 32'hA5A5_A5A5);
        xfer(3, 1'b1, 32'h0004_0034, 32'h0F0F_0F0F, 4'hF, 1'b0, rd);
        xfer(3, 1'b0, 32'h0004_0034, '0, 4'hF, 1'b0, rd);

        // Randomized traffic, including locked (cyc held) sequences.
        for (int n = 0; n < 80; n++) begin
            inst = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) begin
                a = BASE_T[inst] + 4 * DEPTH_T[inst] + 4 * $urandom_range(0, 255);
                xfer(inst, 1'($urandom_range(0, 1)), a, $urandom, 4'hF, 1'($urandom_range(0, 1)), rd);
            end else begin
                wi = $urandom_range(0, 15);
                a  = BASE_T[inst] + 4 * wi;
                wr = !mval[inst][wi] || ($urandom_range(0, 1) == 1);
                xfer(inst, wr, a, $urandom,
                     mval[inst][wi] ? 4'($urandom_range(1, 15)) : 4'hF,
                     1'($urandom_range(0, 1)), rd);
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_sram_slave.md
WISHBONE_SRAM_SLAVE -- requirements
Module: wishbone_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS).
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before each ack/err (0..15).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wishbone  wishbone_interface.slave  -  classic Wishbone B4 responder: adr[31:0], dat_w[31:0], sel[3:0], we, stb, cyc, cti, bte in; dat_r[31:0], ack, err out.
REQ-007 SHALL have port busy  output  1  high while a transfer is latched and not yet acked/errored.

Function
REQ-008 SHALL implement classic single-beat cycles only; cti and bte ignored.
REQ-009 SHALL have states IDLE, WAIT, RESP.
REQ-010 IDLE: when cyc & stb sampled high, SHALL latch adr[31:2], dat_w, sel, we, range check; go to WAIT if WAIT_STATES>0, else RESP.
REQ-011 WAIT: SHALL decrement a wait counter loaded with WAIT_STATES-1; go to RESP when counter is 0.
REQ-012 SHALL hold ack or err high for exactly one cycle, in RESP; RESP SHALL always return to IDLE next edge.
REQ-013 Latency: request sampled at edge k -> ack/err high during the cycle after edge k+WAIT_STATES.
REQ-014 IDLE SHALL NOT accept a new request in the cycle ack/err is high; earliest next accept is the edge ending RESP.
REQ-015 In-range: (adr - BASE_ADDR) < 4*DEPTH_WORDS, 32-bit unsigned compare; word index = (adr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-016 In-range write: SHALL update only bytes with sel[i]=1 on the edge entering RESP, and assert ack.
REQ-017 In-range read: dat_r SHALL equal the full stored word (sel ignored) while ack high, and SHALL reflect writes completed earlier.
REQ-018 Out-of-range access: SHALL assert err instead of ack, perform no write, drive dat_r = 0.
REQ-019 ack and err SHALL never be high together; dat_r SHALL be 0 when ack low.
REQ-020 Abort: if cyc or stb is low at any edge while in WAIT, SHALL return to IDLE with no write, no ack, no err.
REQ-021 Held cyc across multiple stb pulses (locked sequence) SHALL be serviced as independent transfers, no added latency.
REQ-022 busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-023 Memory SHALL be inferable as single-port block RAM (one read or write per cycle).

Reset
REQ-024 On rst: state IDLE, ack=0, err=0, busy=0, dat_r=0, wait counter 0, next cycle.
REQ-025 rst mid-transfer SHALL discard the transfer with no write and no response; stored contents SHALL NOT be cleared.
REQ-026 Request presented while rst high SHALL be ignored.

Verification
REQ-027 WAIT_STATES=0: write adr=BASE+0x10, dat_w=32'hDEADBEEF, sel=4'hF; read same -> ack one cycle after each request, dat_r=32'hDEADBEEF.
REQ-028 Byte select: after REQ-027 write, write dat_w=32'h11223344 sel=4'b0101, read -> dat_r=32'hDE22BE44.
REQ-029 WAIT_STATES=3: read sampled at edge k -> ack high only in cycle after edge k+3, busy high 3 cycles before ack plus ack cycle.
REQ-030 Out-of-range: DEPTH_WORDS=1024, write adr=BASE+0x1000 -> err one cycle, ack=0, word 0 unchanged on readback.
REQ-031 Abort: WAIT_STATES=2, write request then stb low at next edge -> no ack/err, location unchanged, busy low following cycle.
REQ-032 Reset mid-op: WAIT_STATES=4 write, rst asserted during WAIT -> no ack, location retains previous value, next request serviced normally.
